mips_fetch_unit: RTL and testbench
==================================

Name: mips_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the MIPS control unit and datapath.
- Holds the PC and fetches 32-bit instructions from instruction memory through a req/ready handshake.
- Presents the instruction, with opcode and function_bits broken out, under a valid/accept handshake.
- Computes the next PC from the pc_src the control unit returns when the instruction retires.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Must be word-aligned.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; always equals pc
- imem_rdata  input  32  instruction word; valid when imem_ready=1
- imem_ready  input  1  memory has data this cycle
- instr  output  32  registered instruction
- opcode  output  6  instr[31:26]
- function_bits  output  6  instr[5:0]
- instr_valid  output  1  instr/opcode/function_bits valid for the datapath
- instr_accept  input  1  datapath retires the instruction this cycle; pc_src and jr_target are valid
- pc_src  input  2  next-PC select from the control unit (zero_flag already folded in)
- jr_target  input  32  register-file value for jr
- pc  output  32  address of the current instruction
- pc_plus4  output  32  pc+4, for pc_to_reg (jal)
- misalign_err  output  1  sticky; next PC not word-aligned
- fetch_count  output  32  number of retired instructions

Behaviour:
- Reset (already decided): one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Values while rst_n=0: pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, misalign_err=0, fetch_count=0. imem_req is forced to 0 while rst_n=0.
- FSM states: FETCH, ISSUE, HALT.
  - imem_req = (state==FETCH) and rst_n. Combinational.
  - instr_valid = (state==ISSUE). Registered through the state.
- FETCH:
  - imem_addr=pc, held stable until imem_ready=1.
  - On imem_ready=1: instr <= imem_rdata, then go to ISSUE.
  - imem_ready while not in FETCH is ignored.
- ISSUE:
  - instr, pc and pc_plus4 are held stable.
  - On instr_accept=1: pc <= next_pc, fetch_count++ (wraps at 2^32), then go to FETCH.
  - If next_pc[1:0]!=0: pc is not updated, misalign_err <= 1, go to HALT. fetch_count still increments, because the instruction retired.
  - instr_accept outside ISSUE is ignored.
- HALT: no requests, instr_valid=0. Exit only via rst_n.
- Minimum latency is 2 cycles per instruction: ready in the FETCH cycle, accept in the ISSUE cycle. Each memory wait state adds 1 cycle.
- next_pc, all arithmetic mod 2^32:
  - 00 SEQ: pc_plus4
  - 01 BR: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}
  - 10 J: {pc_plus4[31:28], instr[25:0], 2'b00}
  - 11 JR: jr_target
- Only JR can misalign. BR and J targets are always aligned.
- First cycle after rst_n rises: imem_req=1, imem_addr=RESET_PC.
- Reset asserted mid-FETCH or mid-ISSUE: the in-flight fetch is dropped and nothing is retired.
- Memory is required to accept the deasserted req without a response.

Decomposition:
- Package mips_pkg holds:
  - PC_SRC_SEQ=2'b00, PC_SRC_BR=2'b01, PC_SRC_J=2'b10, PC_SRC_JR=2'b11 (shared with central_control)
  - fetch-state enum {FETCH, ISSUE, HALT}
  - INSTR_W=32
- One combinational sub-module, mips_next_pc: inputs pc_plus4, instr, pc_src, jr_target; outputs next_pc and misaligned.

Test Plan:
- Reset, then imem_ready=1 in the first cycle with rdata 32'h2008_0005.
  - Next cycle: instr_valid=1, opcode=6'h08, pc=0, pc_plus4=4.
  - Accept with pc_src=00: imem_addr=4 and fetch_count=1.
- Wait states: hold imem_ready=0 for 3 cycles.
  - imem_req=1, imem_addr constant, instr_valid=0 throughout.
  - instr_valid rises on cycle 5.
- Backward branch: pc=0x10, instr imm16=16'hFFFE, accept with pc_src=01.
  - Next imem_addr=0x0C.
- Jump and jr:
  - pc=0x40, instr=32'h0800_0100, pc_src=10: next addr 0x400.
  - Then pc_src=11 with jr_target=0x1234: next addr 0x1234.
- Misaligned jr: jr_target=0x1236, accept.
  - misalign_err=1 next cycle; pc stays; imem_req stays 0.
  - fetch_count increments once, then freezes.
  - rst_n pulse clears everything.
- Reset mid-wait: drop rst_n while in FETCH with imem_ready=0.
  - Outputs go to reset values immediately (asynchronous), with no clock edge.
  - After release: imem_addr=RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: next-PC select codes, fetch FSM encoding, instruction width.
// Pure declarations with no timing or handshake of their own.
package mips_pkg;

  localparam int INSTR_W = 32;

  // Next-PC select codes, kept identical to the encoding central_control drives.
  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_J   = 2'b10;
  localparam logic [1:0] PC_SRC_JR  = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Bundle of the fetch unit's memory-side and datapath-side handshakes.
// master = fetch unit, slave = memory + control/datapath environment.
interface mips_fetch_unit_if;
  import mips_pkg::*;

  logic                 imem_req;
  logic [31:0]          imem_addr;
  logic [INSTR_W-1:0]   imem_rdata;
  logic                 imem_ready;

  logic [INSTR_W-1:0]   instr;
  logic [5:0]           opcode;
  logic [5:0]           function_bits;
  logic                 instr_valid;
  logic                 instr_accept;
  logic [1:0]           pc_src;
  logic [31:0]          jr_target;

  logic [31:0]          pc;
  logic [31:0]          pc_plus4;
  logic                 misalign_err;
  logic [31:0]          fetch_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ready,
    output instr, opcode, function_bits, instr_valid,
    input  instr_accept, pc_src, jr_target,
    output pc, pc_plus4, misalign_err, fetch_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ready,
    input  instr, opcode, function_bits, instr_valid,
    output instr_accept, pc_src, jr_target,
    input  pc, pc_plus4, misalign_err, fetch_count
  );

endinterface

// File: rtl/mips_next_pc.sv
// Next-PC mux: sequential, PC-relative branch, region jump, or register jump.
// Purely combinational; flags a target that is not word-aligned.
module mips_next_pc
  import mips_pkg::*;
(
  input  logic [31:0]        pc_plus4,
  input  logic [INSTR_W-1:0] instr,
  input  logic [1:0]         pc_src,
  input  logic [31:0]        jr_target,
  output logic [31:0]        next_pc,
  output logic               misaligned
);

  logic [31:0] br_offset;
  logic [31:0] j_target;
  logic        unused_opcode;

  assign br_offset     = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign j_target      = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC_SRC_SEQ: next_pc = pc_plus4;
      PC_SRC_BR:  next_pc = pc_plus4 + br_offset;
      PC_SRC_J:   next_pc = j_target;
      PC_SRC_JR:  next_pc = jr_target;
      default:    next_pc = pc_plus4;
    endcase
  end

  // BR and J targets are aligned by construction, so in practice only JR trips this.
  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch: FETCH waits on imem_ready, ISSUE holds instr until accepted; 2 cycles/instr minimum.
// Memory stalls extend FETCH, datapath stalls extend ISSUE; a misaligned next PC parks the unit in HALT.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  mips_fetch_unit_if.master fu
);

  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_HALT  = HALT;

  logic [1:0]         state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               misalign_q, misalign_d;
  logic [31:0]        count_q, count_d;

  logic [31:0]        pc_plus4;
  logic [31:0]        next_pc;
  logic               next_misaligned;

  assign pc_plus4 = pc_q + 32'd4;

  mips_next_pc u_next_pc (
    .pc_plus4   (pc_plus4),
    .instr      (instr_q),
    .pc_src     (fu.pc_src),
    .jr_target  (fu.jr_target),
    .next_pc    (next_pc),
    .misaligned (next_misaligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    case (state_q)
      ST_FETCH: begin
        if (fu.imem_ready) begin
          instr_d = fu.imem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (fu.instr_accept) begin
          // The instruction retires even when its successor address is unusable.
          count_d = count_q + 32'd1;
          if (next_misaligned) begin
            misalign_d = 1'b1;
            state_d    = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  // Gated by rst_n so the request drops the instant reset asserts, not at the next edge.
  assign fu.imem_req      = (state_q == ST_FETCH) && rst_n;
  assign fu.imem_addr     = pc_q;
  assign fu.instr         = instr_q;
  assign fu.opcode        = instr_q[31:26];
  assign fu.function_bits = instr_q[5:0];
  assign fu.instr_valid   = (state_q == ST_ISSUE);
  assign fu.pc            = pc_q;
  assign fu.pc_plus4      = pc_plus4;
  assign fu.misalign_err  = misalign_q;
  assign fu.fetch_count   = count_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed test of mips_fetch_unit: reset, wait states, branch/jump/jr targets, misalign halt, async reset.
module tb_mips_fetch_unit;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  mips_fetch_unit_if fu_if ();

  mips_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fu    (fu_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One instruction through FETCH (zero wait) and ISSUE; checks the next fetch address afterwards.
  task automatic run_instr(input string tag, input logic [31:0] rd, input logic [1:0] src,
                           input logic [31:0] jr, input logic [31:0] exp_addr);
    fu_if.imem_ready = 1'b1;
    fu_if.imem_rdata = rd;
    tick();
    chk({tag, "_valid"}, {31'd0, fu_if.instr_valid}, 32'd1);
    fu_if.imem_ready   = 1'b0;
    fu_if.instr_accept = 1'b1;
    fu_if.pc_src       = src;
    fu_if.jr_target    = jr;
    tick();
    fu_if.instr_accept = 1'b0;
    chk({tag, "_addr"}, fu_if.imem_addr, exp_addr);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n              = 1'b0;
    fu_if.imem_ready   = 1'b0;
    fu_if.imem_rdata   = 32'h0;
    fu_if.instr_accept = 1'b0;
    fu_if.pc_src       = PC_SRC_SEQ;
    fu_if.jr_target    = 32'h0;
    #1;
    chk("rst_req",   {31'd0, fu_if.imem_req}, 32'd0);
    chk("rst_pc",    fu_if.pc, 32'h0);
    chk("rst_instr", fu_if.instr, 32'h0);
    chk("rst_valid", {31'd0, fu_if.instr_valid}, 32'd0);
    chk("rst_err",   {31'd0, fu_if.misalign_err}, 32'd0);
    chk("rst_cnt",   fu_if.fetch_count, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("first_req",  {31'd0, fu_if.imem_req}, 32'd1);
    chk("first_addr", fu_if.imem_addr, 32'h0);

    // First instruction: addi, zero wait states.
    fu_if.imem_ready = 1'b1;
    fu_if.imem_rdata = 32'h2008_0005;
    tick();
    chk("i0_valid", {31'd0, fu_if.instr_valid}, 32'd1);
    chk("i0_opcode", {26'd0, fu_if.opcode}, 32'h08);
    chk("i0_funct", {26'd0, fu_if.function_bits}, 32'h05);
    chk("i0_pc", fu_if.pc, 32'h0);
    chk("i0_pc4", fu_if.pc_plus4, 32'h4);
    chk("i0_req", {31'd0, fu_if.imem_req}, 32'd0);
    fu_if.imem_ready   = 1'b0;
    fu_if.instr_accept = 1'b1;
    fu_if.pc_src       = PC_SRC_SEQ;
    tick();
    fu_if.instr_accept = 1'b0;
    chk("i0_next_addr", fu_if.imem_addr, 32'h4);
    chk("i0_cnt", fu_if.fetch_count, 32'd1);

    // Three memory wait states at pc=4.
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", {31'd0, fu_if.imem_req}, 32'd1);
      chk("ws_addr", fu_if.imem_addr, 32'h4);
      chk("ws_valid", {31'd0, fu_if.instr_valid}, 32'd0);
      tick();
    end
    fu_if.imem_ready = 1'b1;
    fu_if.imem_rdata = 32'h0109_4020;
    tick();
    chk("ws_valid_rise", {31'd0, fu_if.instr_valid}, 32'd1);
    chk("ws_funct", {26'd0, fu_if.function_bits}, 32'h20);
    fu_if.imem_ready   = 1'b0;
    fu_if.instr_accept = 1'b1;
    tick();
    fu_if.instr_accept = 1'b0;
    chk("ws_next_addr", fu_if.imem_addr, 32'h8);

    run_instr("seq8", 32'h0000_0000, PC_SRC_SEQ, 32'h0, 32'h0C);
    run_instr("seqC", 32'h0000_0000, PC_SRC_SEQ, 32'h0, 32'h10);
    // Backward branch at 0x10, imm -2 words: 0x14 - 8 = 0x0C.
    run_instr("br_back", 32'h1000_FFFE, PC_SRC_BR, 32'h0, 32'h0C);
    // Jump at 0x0C to index 0x10 -> 0x40.
    run_instr("j_40", 32'h0800_0010, PC_SRC_J, 32'h0, 32'h40);
    run_instr("j_400", 32'h0800_0100, PC_SRC_J, 32'h0, 32'h400);
    run_instr("jr_1234", 32'h03E0_0008, PC_SRC_JR, 32'h1234, 32'h1234);
    chk("cnt_before_mis", fu_if.fetch_count, 32'd8);

    // Misaligned jr: retires, pc holds at 0x1234, unit halts.
    run_instr("jr_mis", 32'h03E0_0008, PC_SRC_JR, 32'h1236, 32'h1234);
    chk("mis_err", {31'd0, fu_if.misalign_err}, 32'd1);
    chk("mis_req", {31'd0, fu_if.imem_req}, 32'd0);
    chk("mis_valid", {31'd0, fu_if.instr_valid}, 32'd0);
    chk("mis_cnt", fu_if.fetch_count, 32'd9);
    fu_if.imem_ready   = 1'b1;
    fu_if.instr_accept = 1'b1;
    tick();
    tick();
    tick();
    fu_if.imem_ready   = 1'b0;
    fu_if.instr_accept = 1'b0;
    chk("halt_cnt", fu_if.fetch_count, 32'd9);
    chk("halt_pc", fu_if.pc, 32'h1234);
    chk("halt_req", {31'd0, fu_if.imem_req}, 32'd0);
    chk("halt_valid", {31'd0, fu_if.instr_valid}, 32'd0);

    rst_n = 1'b0;
    #1;
    chk("clr_err", {31'd0, fu_if.misalign_err}, 32'd0);
    chk("clr_cnt", fu_if.fetch_count, 32'd0);
    chk("clr_pc", fu_if.pc, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("clr_req", {31'd0, fu_if.imem_req}, 32'd1);
    chk("clr_addr", fu_if.imem_addr, 32'h0);

    // Retire one, then assert reset asynchronously while waiting on memory.
    run_instr("pre_rst", 32'h0000_0000, PC_SRC_SEQ, 32'h0, 32'h4);
    tick();
    chk("mid_req", {31'd0, fu_if.imem_req}, 32'd1);
    chk("mid_cnt", fu_if.fetch_count, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, fu_if.imem_req}, 32'd0);
    chk("async_pc", fu_if.pc, 32'h0);
    chk("async_cnt", fu_if.fetch_count, 32'd0);
    chk("async_valid", {31'd0, fu_if.instr_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_addr", fu_if.imem_addr, 32'h0);
    chk("rel_req", {31'd0, fu_if.imem_req}, 32'd1);
    chk("rel_cnt", fu_if.fetch_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
